mod_n_counter_prog: RTL and testbench

Runtime-programmable up/down modulo counter, the parametrised successor to the fixed mod-N counter. The modulus is set at elaboration as an upper bound and is reprogrammable at run time through a shadow register that commits only on a period boundary. Adds enable, direction, synchronous clear and load, a combinational carry-out for cascading, and a wrap pulse. It serves as the general timebase and divider primitive for counter and prescaler chains.

---
 rtl/mod_n_counter_prog.sv | 153 +++++++++++++++
 tb/tb_mod_n_counter_prog.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter_prog.sv
// mod_n_counter_prog: runtime-programmable up/down modulo counter.
// The modulus is written into a shadow register and only becomes active on a
// period boundary (wrap or clear), so a running period is never cut short.
// tc is a combinational carry-out meant to drive the next stage's en.
// Optional feature macro: MOD_N_STATUS_EN adds the saturating wraps counter.
module mod_n_counter_prog #(
  parameter  int N_MAX  = 17,
  parameter  int N_DEF  = N_MAX,
  parameter  int WRAP_W = 8,
  localparam int W      = $clog2(N_MAX),
  localparam int MW     = $clog2(N_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          mod_wr,
  input  logic [MW-1:0] mod_in,
  output logic [W-1:0]  count,
  output logic [MW-1:0] mod_cur,
  output logic          tc,
  output logic          wrap,
  output logic          err
`ifdef MOD_N_STATUS_EN
  ,
  output logic [WRAP_W-1:0] wraps
`endif
);

  localparam logic [MW-1:0] MOD_MAX = MW'(N_MAX);
  localparam logic [MW-1:0] MOD_DEF = MW'(N_DEF);
  localparam logic [MW-1:0] MOD_ONE = MW'(1);
  localparam logic [MW-1:0] MOD_ZERO = MW'(0);
  localparam logic [W-1:0]  CNT_ONE = W'(1);
  localparam logic [W-1:0]  CNT_ZERO = W'(0);

  logic [W-1:0]  count_q, count_d;
  logic [MW-1:0] mod_q, mod_d;
  logic [MW-1:0] shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          wrap_q;
  logic          err_q, err_d;

  logic [MW-1:0] count_ext_s;
  logic [MW-1:0] last_s;
  logic          wr_ok_s;
  logic          wr_bad_s;
  logic          wrap_s;
  logic          commit_s;

  // All comparisons are made in modulus width so mod_cur-1 never overflows count.
  assign count_ext_s = MW'(count_q);
  assign last_s      = mod_q - MOD_ONE;
  assign wrap_s      = en & ~clr & ~load &
                       (up ? (count_ext_s == last_s) : (count_ext_s == MOD_ZERO));
  assign commit_s    = clr | wrap_s;
  assign wr_ok_s     = mod_wr & (mod_in != MOD_ZERO) & (mod_in <= MOD_MAX);
  assign wr_bad_s    = mod_wr & ~wr_ok_s;

  // Shadow modulus update and commit; a write on a commit edge goes straight through.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    mod_d     = mod_q;
    if (wr_ok_s) begin
      shadow_d  = mod_in;
      pending_d = 1'b1;
    end else begin
      shadow_d  = shadow_q;
    end
    if (commit_s) begin
      if (pending_d) begin
        mod_d = shadow_d;
      end else begin
        mod_d = mod_q;
      end
      pending_d = 1'b0;
    end else begin
      mod_d = mod_q;
    end
  end

  // Next count with clr > load > en priority; a down-wrap lands on the new modulus.
  always_comb begin
    count_d = count_q;
    err_d   = err_q | wr_bad_s;
    if (clr) begin
      count_d = CNT_ZERO;
    end else if (load) begin
      if (MW'(load_val) < mod_q) begin
        count_d = load_val;
      end else begin
        count_d = W'(last_s);
        err_d   = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        count_d = wrap_s ? CNT_ZERO : (count_q + CNT_ONE);
      end else begin
        count_d = wrap_s ? W'(mod_d - MOD_ONE) : (count_q - CNT_ONE);
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers; reset also discards any pending modulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= CNT_ZERO;
      mod_q     <= MOD_DEF;
      shadow_q  <= MOD_DEF;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      mod_q     <= mod_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      wrap_q    <= wrap_s;
      err_q     <= err_d;
    end
  end

  assign count   = count_q;
  assign mod_cur = mod_q;
  assign tc      = wrap_s;
  assign wrap    = wrap_q;
  assign err     = err_q;

`ifdef MOD_N_STATUS_EN
  localparam logic [WRAP_W-1:0] WRAPS_ONE = WRAP_W'(1);
  logic [WRAP_W-1:0] wraps_q;

  // Saturating count of wrap events, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wraps_q <= '0;
    end else if (wrap_s && (wraps_q != {WRAP_W{1'b1}})) begin
      wraps_q <= wraps_q + WRAPS_ONE;
    end else begin
      wraps_q <= wraps_q;
    end
  end

  assign wraps = wraps_q;
`endif

endmodule

// File: tb/tb_mod_n_counter_prog.sv
// Self-checking bench for mod_n_counter_prog: directed literal checks pin the
// key behaviours, then randomized stimulus is compared every cycle against an
// arithmetic reference model of the counter.
module tb_mod_n_counter_prog;

  localparam int N_MAX  = 17;
  localparam int W      = 5;
  localparam int MW     = 5;
  localparam int WRAP_W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0, mod_wr = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [MW-1:0] mod_in = '0;
  logic [W-1:0]  count;
  logic [MW-1:0] mod_cur;
  logic          tc, wrap, err;
`ifdef MOD_N_STATUS_EN
  logic [WRAP_W-1:0] wraps;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_on   = 1'b0;

  // reference model state
  int m_cnt = 0, m_mod = N_MAX, m_sh = N_MAX, m_wraps = 0;
  bit m_pend = 1'b0, m_err = 1'b0, m_wrap = 1'b0;

  mod_n_counter_prog #(.N_MAX(N_MAX), .N_DEF(N_MAX), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .mod_wr(mod_wr), .mod_in(mod_in),
    .count(count), .mod_cur(mod_cur), .tc(tc), .wrap(wrap), .err(err)
`ifdef MOD_N_STATUS_EN
    , .wraps(wraps)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next state from the counter's rules in plain arithmetic.
  always @(posedge clk or negedge rst_n) begin : model
    int c, md, sh;
    bit pd, e, w;
    if (!rst_n) begin
      m_cnt <= 0; m_mod <= N_MAX; m_sh <= N_MAX; m_pend <= 1'b0;
      m_err <= 1'b0; m_wrap <= 1'b0; m_wraps <= 0;
    end else begin
      sh = m_sh; pd = m_pend; e = m_err; md = m_mod; c = m_cnt;
      if (mod_wr) begin
        if (mod_in >= 1 && mod_in <= N_MAX) begin sh = int'(mod_in); pd = 1'b1; end
        else e = 1'b1;
      end
      w = en && !clr && !load && (up ? (m_cnt == m_mod - 1) : (m_cnt == 0));
      if (clr || w) begin
        if (pd) md = sh;
        pd = 1'b0;
      end
      if (clr) c = 0;
      else if (load) begin
        if (int'(load_val) < m_mod) c = int'(load_val);
        else begin c = m_mod - 1; e = 1'b1; end
      end else if (en) begin
        if (up) c = (m_cnt + 1) % m_mod;
        else c = (m_cnt == 0) ? md - 1 : m_cnt - 1;
      end
      m_cnt <= c; m_mod <= md; m_sh <= sh; m_pend <= pd; m_err <= e; m_wrap <= w;
      if (w && m_wraps < (1 << WRAP_W) - 1) m_wraps <= m_wraps + 1;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", int'(count), m_cnt);
      chk("mod_cur", int'(mod_cur), m_mod);
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("err", int'(err), int'(m_err));
      chk("tc", int'(tc), int'(en && !clr && !load &&
                              (up ? (m_cnt == m_mod - 1) : (m_cnt == 0))));
`ifdef MOD_N_STATUS_EN
      chk("wraps", int'(wraps), m_wraps);
`endif
    end
  end

  task automatic drive(input bit e_i, input bit u_i, input bit c_i, input bit l_i,
                       input int lv, input bit w_i, input int mi);
    en = e_i; up = u_i; clr = c_i; load = l_i; load_val = W'(lv);
    mod_wr = w_i; mod_in = MW'(mi);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_mod", int'(mod_cur), 17);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err", int'(err), 0);

    drive(1, 1, 0, 0, 0, 0, 0);
    repeat (16) tick();
    chk("up_16", int'(count), 16);
    chk("tc_16", int'(tc), 1);
    tick();
    chk("up_wrap_cnt", int'(count), 0);
    chk("up_wrap_pulse", int'(wrap), 1);
    repeat (7) tick();
    chk("up_7", int'(count), 7);
    drive(1, 1, 1, 1, 3, 0, 0);
    tick();
    chk("clr_prio", int'(count), 0);
    drive(0, 1, 0, 1, 20, 0, 0);
    tick();
    chk("load_over", int'(count), 16);
    chk("load_err", int'(err), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("down_15", int'(count), 15);
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("dir_flip", int'(count), 16);
    chk("dir_flip_nowrap", int'(wrap), 0);
    drive(1, 1, 0, 0, 0, 1, 5);
    tick();
    chk("wt_count", int'(count), 0);
    chk("wt_mod", int'(mod_cur), 5);
    drive(1, 1, 0, 0, 0, 1, 3);
    tick();
    chk("pend_mod", int'(mod_cur), 5);
    drive(1, 1, 0, 0, 0, 0, 0);
    repeat (4) tick();
    chk("commit_mod", int'(mod_cur), 3);
    chk("commit_cnt", int'(count), 0);
    drive(0, 1, 1, 0, 0, 1, 1);
    tick();
    chk("mod1_set", int'(mod_cur), 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("mod1_cnt", int'(count), 0);
    chk("mod1_wrap", int'(wrap), 1);
    chk("mod1_tc", int'(tc), 1);
    drive(0, 1, 0, 0, 0, 1, 9);
    tick();
    chk("hold_mod", int'(mod_cur), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_mod", int'(mod_cur), 17);
    chk("arst_err", int'(err), 0);
    chk("arst_wrap", int'(wrap), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(0, 1, 1, 0, 0, 0, 0);
    tick();
    chk("pend_lost", int'(mod_cur), 17);
    drive(0, 1, 0, 0, 0, 1, 0);
    tick();
    chk("bad_wr0_err", int'(err), 1);
    drive(0, 1, 1, 0, 0, 1, 18);
    tick();
    chk("bad_wr18_mod", int'(mod_cur), 17);

    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) up = ~up;
      clr      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom_range(0, 31));
      mod_wr   = ($urandom_range(0, 14) == 0);
      mod_in   = MW'($urandom_range(0, 19));
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
